range_gate_gen: RTL and testbench

Parametrised successor to the fixed range decoder in the decode top level. On each radar trigger (synclk) it waits a programmable start delay, then sweeps a range-bin counter over NUM_BINS bins of runtime-selectable length. For every bin it emits one ADC start strobe. It also flags triggers that arrive mid-sweep and can optionally restart the sweep on them.

---
 rtl/range_gate_gen.sv | 154 +++++++++++++++
 tb/tb_range_gate_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/range_gate_gen.sv
// Range-gate generator: trigger sync, programmable start delay, then a NUM_BINS range-bin sweep
// with one ADC start strobe per bin, overrun flagging and optional restart on mid-sweep triggers.
module range_gate_gen #(
  parameter int RANGE_W  = 10,
  parameter int NUM_BINS = 1024,
  parameter int DIV_W    = 8,
  parameter int DELAY_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               synclk,
  input  logic [DELAY_W-1:0] delay,
  input  logic [DIV_W-1:0]   bin_div,
  input  logic               restart_en,
  input  logic               ovr_clr,
  output logic [RANGE_W-1:0] range,
  output logic               pros,
  output logic               adc_start,
  output logic               osynclk,
  output logic               sweep_done,
  output logic               overrun
);

  localparam logic [RANGE_W-1:0] LAST_BIN = RANGE_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SWEEP} state_t;

  state_t             state, state_nx;
  logic [DELAY_W-1:0] dcnt, dcnt_nx;
  logic [DIV_W-1:0]   div_cnt, div_nx;
  logic [DIV_W-1:0]   div_lat, div_lat_nx;
  logic [RANGE_W-1:0] range_nx;
  logic               pros_nx, adc_nx, done_nx, ovr_nx;
  logic               accept, last_clk;
  logic               sync_q1, sync_q2, sync_q3, sync_evt;

  // Two-flop synchroniser plus registered rising-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      sync_q3  <= 1'b0;
      sync_evt <= 1'b0;
    end else begin
      sync_q1  <= synclk;
      sync_q2  <= sync_q1;
      sync_q3  <= sync_q2;
      sync_evt <= sync_q2 & ~sync_q3;
    end
  end

  assign osynclk = sync_evt;

  always_comb begin
    state_nx   = state;
    dcnt_nx    = dcnt;
    div_nx     = div_cnt;
    div_lat_nx = div_lat;
    range_nx   = range;
    pros_nx    = pros;
    adc_nx     = 1'b0;
    done_nx    = 1'b0;
    ovr_nx     = overrun & ~ovr_clr;
    accept     = 1'b0;
    last_clk   = (div_cnt == div_lat) && (range == LAST_BIN);

    case (state)
      S_IDLE: begin
        range_nx = '0;
        pros_nx  = 1'b0;
        accept   = sync_evt;
      end
      S_DELAY: begin
        dcnt_nx = dcnt - DELAY_W'(1);
        if (dcnt == DELAY_W'(1)) begin
          state_nx = S_SWEEP;
          range_nx = '0;
          div_nx   = '0;
          pros_nx  = 1'b1;
          adc_nx   = 1'b1;
        end
        if (sync_evt) begin
          ovr_nx = 1'b1;
          accept = restart_en;
        end
      end
      S_SWEEP: begin
        if (div_cnt == div_lat) begin
          div_nx = '0;
          if (range == LAST_BIN) begin
            done_nx  = 1'b1;
            pros_nx  = 1'b0;
            range_nx = '0;
            state_nx = S_IDLE;
            accept   = sync_evt;
          end else begin
            range_nx = range + RANGE_W'(1);
            adc_nx   = 1'b1;
          end
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
        // A trigger on the final clock belongs to the next sweep, not an overrun
        if (sync_evt && !last_clk) begin
          ovr_nx = 1'b1;
          accept = restart_en;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (accept) begin
      div_lat_nx = bin_div;
      range_nx   = '0;
      div_nx     = '0;
      if (delay == '0) begin
        state_nx = S_SWEEP;
        pros_nx  = 1'b1;
        adc_nx   = 1'b1;
      end else begin
        state_nx = S_DELAY;
        dcnt_nx  = delay;
        adc_nx   = 1'b0;
        // pros stays high across a restart delay, low when starting from idle
        pros_nx  = pros & ~((state == S_SWEEP) && last_clk);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      dcnt       <= '0;
      div_cnt    <= '0;
      div_lat    <= '0;
      range      <= '0;
      pros       <= 1'b0;
      adc_start  <= 1'b0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      dcnt       <= dcnt_nx;
      div_cnt    <= div_nx;
      div_lat    <= div_lat_nx;
      range      <= range_nx;
      pros       <= pros_nx;
      adc_start  <= adc_nx;
      sweep_done <= done_nx;
      overrun    <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_range_gate_gen.sv
// Bench for range_gate_gen: directed scenarios plus random triggers, every cycle compared
// against a schedule model (sweep start cycle, bin length) derived from the trigger times.
module tb_range_gate_gen;

  localparam int RANGE_W  = 10;
  localparam int NUM_BINS = 1024;
  localparam int DIV_W    = 8;
  localparam int DELAY_W  = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               synclk = 1'b0;
  logic [DELAY_W-1:0] delay = '0;
  logic [DIV_W-1:0]   bin_div = '0;
  logic               restart_en = 1'b0;
  logic               ovr_clr = 1'b0;
  logic [RANGE_W-1:0] range;
  logic               pros, adc_start, osynclk, sweep_done, overrun;

  range_gate_gen #(
    .RANGE_W(RANGE_W), .NUM_BINS(NUM_BINS), .DIV_W(DIV_W), .DELAY_W(DELAY_W)
  ) dut (
    .clk(clk), .reset(reset), .synclk(synclk), .delay(delay), .bin_div(bin_div),
    .restart_en(restart_en), .ovr_clr(ovr_clr), .range(range), .pros(pros),
    .adc_start(adc_start), .osynclk(osynclk), .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Schedule model: the active sweep starts at s_at and lasts NUM_BINS*(bd+1) cycles
  int evt_q[$];
  bit have      = 1'b0;
  int s_at      = 0;
  int bd        = 0;
  int pend_from = 0;
  bit pend_pros = 1'b0;
  int prev_done = -1;
  bit exp_ovr   = 1'b0;
  int hold      = 0;
  int clr_at    = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic trig();
    synclk = 1'b1;
    hold   = 4;
    evt_q.push_back(cyc + 3);
  endtask

  task automatic compare();
    logic e_pros, e_adc, e_done, e_osy;
    int   e_rng, len;
    e_pros = 1'b0; e_adc = 1'b0; e_done = 1'b0; e_rng = 0;
    e_osy  = (evt_q.size() > 0) && (evt_q[0] == cyc);
    if (have) begin
      len = NUM_BINS * (bd + 1);
      if (cyc >= s_at && cyc < s_at + len) begin
        e_pros = 1'b1;
        e_rng  = (cyc - s_at) / (bd + 1);
        e_adc  = ((cyc - s_at) % (bd + 1)) == 0;
      end else if (cyc > pend_from && cyc < s_at) begin
        e_pros = pend_pros;
      end
      if (cyc == s_at + len) e_done = 1'b1;
    end
    if (cyc == prev_done) e_done = 1'b1;
    chk("range", 32'(range), 32'(e_rng));
    chk("pros", 32'(pros), 32'(e_pros));
    chk("adc_start", 32'(adc_start), 32'(e_adc));
    chk("sweep_done", 32'(sweep_done), 32'(e_done));
    chk("osynclk", 32'(osynclk), 32'(e_osy));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  // Apply the clock edge that ends cycle cyc to the model
  task automatic model_edge();
    bit ev, act, fin, set;
    int len;
    ev = (evt_q.size() > 0) && (evt_q[0] == cyc);
    if (ev) void'(evt_q.pop_front());
    len = NUM_BINS * (bd + 1);
    act = have && (cyc < s_at + len);
    fin = have && (cyc == s_at + len - 1);
    set = ev && act && !fin;
    if (ev && (!act || fin || restart_en)) begin
      if (fin) prev_done = cyc + 1;
      pend_pros = act && !fin && (cyc >= s_at || pend_pros);
      have      = 1'b1;
      s_at      = cyc + int'(delay) + 1;
      bd        = int'(bin_div);
      pend_from = cyc;
    end
    exp_ovr = set ? 1'b1 : (ovr_clr ? 1'b0 : exp_ovr);
  endtask

  task automatic step();
    if (hold > 0) begin
      hold--;
      if (hold == 0) synclk = 1'b0;
    end
    ovr_clr = (cyc == clr_at) || ($urandom_range(0, 127) == 0);
    if (reset) model_edge();
    @(posedge clk);
    cyc++;
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_range", 32'(range), 32'd0);
    chk("rst_pros", 32'(pros), 32'd0);
    chk("rst_adc", 32'(adc_start), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    evt_q.delete();
    have      = 1'b0;
    prev_done = -1;
    exp_ovr   = 1'b0;
    pend_pros = 1'b0;
    synclk    = 1'b0;
    hold      = 0;
  endtask

  initial begin
    run(3);
    chk("init_range", 32'(range), 32'd0);
    chk("init_osynclk", 32'(osynclk), 32'd0);
    chk("init_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    run(4);

    // Back-to-back bins, no delay
    delay = 8'd0; bin_div = 8'd0; restart_en = 1'b0;
    trig(); run(1100);

    // Start delay and 4-clock bins
    delay = 8'd5; bin_div = 8'd3;
    trig(); run(4200);

    // Ignored mid-sweep trigger sets overrun, later cleared
    delay = 8'd5; bin_div = 8'd0; restart_en = 1'b0;
    trig(); run(310); trig(); run(800);
    clr_at = cyc; run(20);

    // Restart on mid-sweep trigger with a 2-clock delay
    delay = 8'd0; restart_en = 1'b1;
    trig(); run(301);
    delay = 8'd2;
    trig(); run(1100);

    // Divider change mid-sweep only takes effect on the next trigger
    delay = 8'd0; bin_div = 8'd3; restart_en = 1'b0;
    trig(); run(100);
    bin_div = 8'd7; run(4120);
    trig(); run(8300);

    // Trigger landing on the final clock of a sweep
    bin_div = 8'd0; delay = 8'd0;
    trig(); run(1024); trig(); run(1100);

    // Asynchronous reset mid-sweep
    trig(); run(503);
    mid_reset();
    run(3);
    reset = 1'b1;
    run(3);
    trig(); run(1100);

    // Overrun set and clear in the same clock
    trig(); run(50);
    trig(); clr_at = cyc + 3; run(1100);

    // Random triggers and settings
    for (int k = 0; k < 12; k++) begin
      delay      = DELAY_W'($urandom_range(0, 15));
      bin_div    = DIV_W'($urandom_range(0, 3));
      restart_en = 1'($urandom_range(0, 1));
      trig();
      run($urandom_range(8, 3000));
    end
    run(4200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
